// File: rtl/noise_sched.sv
// Round-robin arbiter sharing one stepped LFSR noise generator among NUM_REQ voices.
// Each grant steps the generator SHIFTS times, then returns the captured word tagged with the requester id.
module noise_sched #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 24,
    parameter  int SHIFTS  = 24,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW      = $clog2(SHIFTS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               adv_o,
    input  logic [WIDTH-1:0]   noise_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   sample_o,
    output logic [IW-1:0]      id_o,
    output logic               busy_o
);

    // state   | meaning
    // IDLE    | waiting for a request; valid_o may be high in the first IDLE cycle
    // STEP    | generator stepped once per cycle, SHIFTS cycles in total
    // DELIVER | generator settled; word captured at the closing edge
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        id_q, id_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 adv_q, adv_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic [WIDTH-1:0]     sample_q, sample_d;
    logic [IW-1:0]        ido_q, ido_d;

    logic                 sel_found;
    logic [IW-1:0]        sel_idx;

    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        logic [IW-1:0] k;
        sel_found = 1'b0;
        sel_idx   = '0;
        k         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = IW'((int'(ptr_q) + i) % NUM_REQ);
            if (!sel_found && req_i[k]) begin
                sel_found = 1'b1;
                sel_idx   = k;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        adv_d    = 1'b0;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        sample_d = sample_q;
        ido_d    = ido_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (sel_found) begin
                    id_d    = sel_idx;
                    ptr_d   = (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                    gnt_d   = NUM_REQ'(1) << sel_idx;
                    adv_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = STEP;
                end
            end
            STEP: begin
                busy_d = 1'b1;
                if (cnt_q == CW'(SHIFTS - 1)) begin
                    state_d = DELIVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    adv_d = 1'b1;
                end
            end
            DELIVER: begin
                busy_d   = 1'b0;
                sample_d = noise_i;
                ido_d    = id_q;
                valid_d  = 1'b1;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            adv_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            sample_q <= '0;
            ido_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            adv_q    <= adv_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            sample_q <= sample_d;
            ido_q    <= ido_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign adv_o    = adv_q;
    assign valid_o  = valid_q;
    assign busy_o   = busy_q;
    assign sample_o = sample_q;
    assign id_o     = ido_q;

endmodule

// File: doc/noise_sched.md
Name: noise_sched

Overview:
- Round-robin scheduler that shares the single 24-bit LFSR noise generator among several synth voices.
- Consecutive LFSR states are shifted copies of one another. For each granted request the block therefore steps the generator SHIFTS times, then captures the decorrelated word and returns it tagged with the requester ID.
- Sits between the voice array and a stepped (enable-gated) noise generator.

Parameters:
- NUM_REQ, 4, number of requesting voices (>=1).
- WIDTH, 24, noise word width.
- SHIFTS, 24, generator advances per delivered sample (>=1).

Ports:
- clk_i  input  1  system clock; the only clock in the block.
- rst_ni  input  1  reset; asynchronous, active-low.
- req_i  input  NUM_REQ  level request per voice.
- gnt_o  output  NUM_REQ  one-hot grant; pulses for one cycle per accepted request.
- adv_o  output  1  step enable to the noise generator; the generator advances one state on each rising clk_i edge where adv_o=1.
- noise_i  input  WIDTH  current generator state.
- valid_o  output  1  one-cycle pulse; sample_o and id_o are valid.
- sample_o  output  WIDTH  delivered noise word.
- id_o  output  $clog2(NUM_REQ) (min 1)  requester index of sample_o.
- busy_o  output  1  high from grant until the cycle before valid_o.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - State=IDLE.
  - gnt_o=0, adv_o=0, valid_o=0, sample_o=0, id_o=0, busy_o=0.
  - Round-robin pointer=0; step counter=0.
- States: IDLE -> STEP -> DELIVER -> IDLE. All outputs are registered.
- IDLE:
  - req_i is sampled at each edge.
  - If any bit is set, select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch the selection as id; set pointer to (id+1) mod NUM_REQ; go to STEP.
  - If no bit is set, remain in IDLE.
- STEP:
  - In the first STEP cycle: gnt_o=onehot(id) for exactly that cycle, busy_o=1.
  - adv_o=1 for exactly SHIFTS consecutive cycles, starting with the grant cycle.
  - Counter runs 0..SHIFTS-1 (width $clog2(SHIFTS+1)); go to DELIVER after the last adv cycle.
- DELIVER (one cycle):
  - adv_o=0, busy_o=1.
  - At the closing edge: sample_o<=noise_i, id_o<=id, valid_o<=1, busy_o<=0; state goes to IDLE.
- valid_o is high in the first IDLE cycle after DELIVER. req_i is sampled in that same cycle, so back-to-back service is possible.
- Latency:
  - Request sampled at edge E0 -> gnt_o and first adv_o in cycle 1.
  - adv_o in cycles 1..SHIFTS; DELIVER in cycle SHIFTS+1; valid_o in cycle SHIFTS+2.
  - Maximum throughput is one sample per SHIFTS+2 cycles.
- Requests:
  - req_i is level-sensitive; a voice holds it until it sees valid_o with its id.
  - Dropping req_i after the grant does not abort the transaction; the sample is still delivered.
  - A voice whose req_i stays high after service is re-eligible, but the pointer has already passed it.
- Outputs between events:
  - sample_o and id_o hold their last values until the next DELIVER.
  - valid_o and gnt_o are single-cycle pulses only.
- NUM_REQ=1: pointer stays 0 and requester 0 is served whenever requesting.
- SHIFTS=1: adv_o is high only in the grant cycle; valid_o arrives in cycle 3.
- Reset asserted mid-operation:
  - All outputs drop immediately; the in-flight sample is discarded with no valid_o.
  - Pointer returns to 0.
  - The generator state is not restored by this block.

Test Plan:
- Hold rst_ni=0 with req_i=4'b1111 -> all outputs 0 and adv_o never high. Release -> gnt_o=4'b0001 one cycle after the first sampled edge.
- Reset the generator to seed 24'h8964CE; drive req_i=4'b0100 only, SHIFTS=24:
  - gnt_o=4'b0100 for exactly 1 cycle; adv_o high exactly 24 cycles.
  - valid_o in cycle 26 with id_o=2 and sample_o equal to the reference LFSR model advanced 24 steps from 24'h8964CE.
- Hold req_i=4'b1111 continuously -> grants in order 0,1,2,3,0; grant pulses spaced 26 cycles apart; ids on valid_o match the same order.
- After serving requester 2, drive req_i=4'b1001 -> requester 3 is served before requester 0.
- Pull rst_ni low during STEP, 10 cycles after the grant:
  - adv_o falls asynchronously; no valid_o.
  - After release, req_i=4'b1010 is granted to requester 1 (pointer=0).
- Drop req_i 5 cycles into STEP -> valid_o still issued with the same id. Separately, with SHIFTS=1 -> adv_o for 1 cycle and valid_o 3 cycles after the sampled request.
